// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state and grant encodings for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_grant_e;

endpackage

// File: rtl/mem_bus_arbiter_req_latch.sv
// Holds the granted request (wr/wstrb/addr/wdata) for the whole bus transaction.
module arb_req_latch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                wr_in,
  input  logic [DATA_W/8-1:0] wstrb_in,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  output logic                wr_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o
);

  logic                wr_q,    wr_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  always_comb begin
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load) begin
      wr_d    = wr_in;
      wstrb_d = wstrb_in;
      addr_d  = addr_in;
      wdata_d = wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wr_o    = wr_q;
  assign wstrb_o = wstrb_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the IF and MEM ports, one transaction at a time,
// with the data port taking fixed priority; also produces the pipeline stall requests.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                stall_for_if,
  output logic                stall_for_mem
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e state_q, state_d;
  arb_grant_e grant_q, grant_d;

  logic              ld_en;
  logic              ld_wr;
  logic [STRB_W-1:0] ld_wstrb;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              lat_wr;
  logic [STRB_W-1:0] lat_wstrb;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              xfer_done;

  arb_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_latch (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_en),
    .wr_in    (ld_wr),
    .wstrb_in (ld_wstrb),
    .addr_in  (ld_addr),
    .wdata_in (ld_wdata),
    .wr_o     (lat_wr),
    .wstrb_o  (lat_wstrb),
    .addr_o   (lat_addr),
    .wdata_o  (lat_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ld_en        = 1'b0;
    ld_wr        = 1'b0;
    ld_wstrb     = '0;
    ld_addr      = '0;
    ld_wdata     = '0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    bus_req      = 1'b0;
    xfer_done    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (data_req) begin
          grant_d      = GNT_DATA;
          data_addr_ok = 1'b1;
          ld_en        = 1'b1;
          ld_wr        = data_wr;
          ld_wstrb     = data_wstrb;
          ld_addr      = data_addr;
          ld_wdata     = data_wdata;
          state_d      = ARB_ADDR;
        end else if (inst_req) begin
          grant_d      = GNT_INST;
          inst_addr_ok = 1'b1;
          ld_en        = 1'b1;
          ld_addr      = inst_addr;
          state_d      = ARB_ADDR;
        end
      end
      // A data_ok arriving together with addr_ok here is deliberately dropped.
      ARB_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (bus_data_ok) begin
          xfer_done = 1'b1;
          state_d   = ARB_IDLE;
          grant_d   = GNT_NONE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // Downstream fields are only driven while the address phase is open.
  assign bus_wr    = bus_req & lat_wr;
  assign bus_wstrb = bus_req ? lat_wstrb : '0;
  assign bus_addr  = bus_req ? lat_addr  : '0;
  assign bus_wdata = bus_req ? lat_wdata : '0;

  assign inst_data_ok = xfer_done & (grant_q == GNT_INST);
  assign data_data_ok = xfer_done & (grant_q == GNT_DATA);
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;

  assign stall_for_if  = (inst_req & ~inst_addr_ok) |
                         ((grant_q == GNT_INST) & (state_q != ARB_IDLE) & ~bus_data_ok);
  assign stall_for_mem = (data_req & ~data_addr_ok) |
                         ((grant_q == GNT_DATA) & (state_q != ARB_IDLE) & ~bus_data_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven check of mem_bus_arbiter: one record per clock cycle,
// combinational outputs compared mid-cycle after inputs settle.
module tb_mem_bus_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [3:0]  S0  = 4'h0;
  localparam logic [3:0]  S3  = 4'b0011;
  localparam logic [31:0] IA  = 32'hBFC0_0000;
  localparam logic [31:0] DA  = 32'h8000_0010;
  localparam logic [31:0] WA  = 32'h8000_0020;
  localparam logic [31:0] WD  = 32'h1234_5678;
  localparam logic [31:0] RD1 = 32'h2402_0001;
  localparam logic [31:0] RD2 = 32'hCAFE_F00D;

  typedef struct packed {
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  wstrb;
    logic [31:0] data_addr;
    logic [31:0] wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
  } in_t;

  typedef struct packed {
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        stall_if;
    logic        stall_mem;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall_for_if, stall_for_mem;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_wstrb    (bus_wstrb),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .stall_for_if (stall_for_if),
    .stall_for_mem(stall_for_mem)
  );

  function automatic in_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw, logic [3:0] ws,
                                logic [31:0] da, logic [31:0] wd, logic aok, logic dok,
                                logic [31:0] rd);
    in_t r;
    r = '{ir, ia, dr, dw, ws, da, wd, aok, dok, rd};
    return r;
  endfunction

  function automatic out_t mk_out(logic iao, logic ido, logic [31:0] ird, logic dao, logic ddo,
                                  logic [31:0] drd, logic breq, logic bwr, logic [3:0] bws,
                                  logic [31:0] ba, logic [31:0] bwd, logic sif, logic smem);
    out_t r;
    r = '{iao, ido, ird, dao, ddo, drd, breq, bwr, bws, ba, bwd, sif, smem};
    return r;
  endfunction

  task automatic drive(input in_t i);
    inst_req    = i.inst_req;
    inst_addr   = i.inst_addr;
    data_req    = i.data_req;
    data_wr     = i.data_wr;
    data_wstrb  = i.wstrb;
    data_addr   = i.data_addr;
    data_wdata  = i.wdata;
    bus_addr_ok = i.bus_addr_ok;
    bus_data_ok = i.bus_data_ok;
    bus_rdata   = i.bus_rdata;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = '{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
            bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, stall_for_if, stall_for_mem};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s", name);
    end
  endtask

  // One cycle: drive at the falling edge, compare 1ns later, state advances on the next rise.
  task automatic step(input string name, input in_t i, input out_t o);
    @(negedge clk);
    drive(i);
    #1;
    check(name, o);
  endtask

  initial begin
    in_t  idle_in;
    out_t zero_out;
    idle_in  = mk_in(L, Z32, L, L, S0, Z32, Z32, L, L, Z32);
    zero_out = mk_out(L, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, L, L);

    // Instruction read with a zero-wait bus.
    vecs.push_back('{"if_grant", mk_in(H, IA, L, L, S0, Z32, Z32, L, L, Z32),
                     mk_out(H, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, L, L)});
    vecs.push_back('{"if_addr", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, Z32),
                     mk_out(L, L, Z32, L, L, Z32, H, L, S0, IA, Z32, H, L)});
    vecs.push_back('{"if_data", mk_in(L, Z32, L, L, S0, Z32, Z32, L, H, RD1),
                     mk_out(L, H, RD1, L, L, Z32, L, L, S0, Z32, Z32, L, L)});
    // Collision: data first, IF holds its request and stalls.
    vecs.push_back('{"col_grant", mk_in(H, IA, H, L, S0, DA, Z32, L, L, Z32),
                     mk_out(L, L, Z32, H, L, Z32, L, L, S0, Z32, Z32, H, L)});
    vecs.push_back('{"col_addr", mk_in(H, IA, L, L, S0, Z32, Z32, H, L, Z32),
                     mk_out(L, L, Z32, L, L, Z32, H, L, S0, DA, Z32, H, H)});
    vecs.push_back('{"col_data", mk_in(H, IA, L, L, S0, Z32, Z32, L, H, RD2),
                     mk_out(L, L, Z32, L, H, RD2, L, L, S0, Z32, Z32, H, L)});
    vecs.push_back('{"col_if_grant", mk_in(H, IA, L, L, S0, Z32, Z32, L, L, Z32),
                     mk_out(H, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, L, L)});
    vecs.push_back('{"col_if_addr", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, Z32),
                     mk_out(L, L, Z32, L, L, Z32, H, L, S0, IA, Z32, H, L)});
    vecs.push_back('{"col_if_data", mk_in(L, Z32, L, L, S0, Z32, Z32, L, H, RD1),
                     mk_out(L, H, RD1, L, L, Z32, L, L, S0, Z32, Z32, L, L)});
    // Partial-strobe write.
    vecs.push_back('{"wr_grant", mk_in(L, Z32, H, H, S3, WA, WD, L, L, Z32),
                     mk_out(L, L, Z32, H, L, Z32, L, L, S0, Z32, Z32, L, L)});
    vecs.push_back('{"wr_addr", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, Z32),
                     mk_out(L, L, Z32, L, L, Z32, H, H, S3, WA, WD, L, H)});
    vecs.push_back('{"wr_data", mk_in(L, Z32, L, L, S0, Z32, Z32, L, H, RD2),
                     mk_out(L, L, Z32, L, H, RD2, L, L, S0, Z32, Z32, L, L)});
    // Stray handshakes while idle must be ignored.
    vecs.push_back('{"stray_idle", mk_in(L, Z32, L, L, S0, Z32, Z32, H, H, RD1), zero_out});
    // Wait states: addr_ok after 3 extra cycles, data_ok after 2.
    vecs.push_back('{"ws_grant", mk_in(H, IA, L, L, S0, Z32, Z32, L, L, Z32),
                     mk_out(H, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, L, L)});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{$sformatf("ws_addr_wait%0d", k), idle_in,
                       mk_out(L, L, Z32, L, L, Z32, H, L, S0, IA, Z32, H, L)});
    vecs.push_back('{"ws_addr_ok", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, Z32),
                     mk_out(L, L, Z32, L, L, Z32, H, L, S0, IA, Z32, H, L)});
    vecs.push_back('{"ws_data_wait0", idle_in,
                     mk_out(L, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, H, L)});
    vecs.push_back('{"ws_data_wait1", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, RD2),
                     mk_out(L, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, H, L)});
    vecs.push_back('{"ws_data_ok", mk_in(L, Z32, L, L, S0, Z32, Z32, L, H, RD1),
                     mk_out(L, H, RD1, L, L, Z32, L, L, S0, Z32, Z32, L, L)});
    // addr_ok and data_ok together in ADDR: only the address phase completes.
    vecs.push_back('{"same_grant", mk_in(L, Z32, H, L, S0, DA, Z32, L, L, Z32),
                     mk_out(L, L, Z32, H, L, Z32, L, L, S0, Z32, Z32, L, L)});
    vecs.push_back('{"same_both_ok", mk_in(L, Z32, L, L, S0, Z32, Z32, H, H, RD2),
                     mk_out(L, L, Z32, L, L, Z32, H, L, S0, DA, Z32, L, L)});
    vecs.push_back('{"same_data_wait", idle_in,
                     mk_out(L, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, L, H)});
    vecs.push_back('{"same_data_ok", mk_in(L, Z32, L, L, S0, Z32, Z32, L, H, RD2),
                     mk_out(L, L, Z32, L, H, RD2, L, L, S0, Z32, Z32, L, L)});

    drive(idle_in);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", zero_out);

    foreach (vecs[n]) step(vecs[n].name, vecs[n].i, vecs[n].o);

    // Reset while a data read sits in the data phase.
    step("rst_seq_grant", mk_in(L, Z32, H, L, S0, DA, Z32, L, L, Z32),
         mk_out(L, L, Z32, H, L, Z32, L, L, S0, Z32, Z32, L, L));
    step("rst_seq_addr", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, Z32),
         mk_out(L, L, Z32, L, L, Z32, H, L, S0, DA, Z32, L, H));
    @(negedge clk);
    drive(idle_in);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_seq_after", zero_out);
    step("rst_seq_if_grant", mk_in(H, IA, L, L, S0, Z32, Z32, L, L, Z32),
         mk_out(H, L, Z32, L, L, Z32, L, L, S0, Z32, Z32, L, L));
    step("rst_seq_if_addr", mk_in(L, Z32, L, L, S0, Z32, Z32, H, L, Z32),
         mk_out(L, L, Z32, L, L, Z32, H, L, S0, IA, Z32, H, L));
    step("rst_seq_if_data", mk_in(L, Z32, L, L, S0, Z32, Z32, L, H, RD1),
         mk_out(L, H, RD1, L, L, Z32, L, L, S0, Z32, Z32, L, L));

    @(negedge clk);
    drive(idle_in);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
